// File: rtl/serial_compare_seq_pkg.sv
// -----------------------------------------------------------------------------
// serial_compare_seq_pkg
//   Shared definitions for the serial magnitude comparator:
//   - 3-bit compare result encodings, {[2]=A>B, [1]=A<B, [0]=A=B}
//   - sequencer state encoding (IDLE / RUN / DONE)
//   - helper that sizes the nibble index counter
// -----------------------------------------------------------------------------
package serial_compare_seq_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqStateT;

  // A single-nibble compare still needs a 1-bit counter to exist.
  function automatic int idxWidth(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/serial_compare_seq_if.sv
// -----------------------------------------------------------------------------
// serial_compare_seq_if
//   Start / operand / result bundle of the serial comparator.
//   iStart          start request (sampled only while the comparator is idle)
//   iData_a/iData_b WIDTH-bit unsigned operands, captured on an accepted start
//   oBusy           comparator is working (RUN or DONE)
//   oDone           one-cycle pulse, oData valid from this cycle
//   oData           result {[2]=A>B, [1]=A<B, [0]=A=B}
//   Modports: master = requester, slave = comparator.
// -----------------------------------------------------------------------------
interface serial_compare_seq_if #(
  parameter int WIDTH = 16
);

  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       oData;

  modport master (
    output iStart, iData_a, iData_b,
    input  oBusy, oDone, oData
  );

  modport slave (
    input  iStart, iData_a, iData_b,
    output oBusy, oDone, oData
  );

endinterface

// File: rtl/serial_compare_seq_cmp4.sv
// -----------------------------------------------------------------------------
// DataCompare4
//   4-bit unsigned cascade comparator cell. If the nibbles differ the cell
//   decides on its own; if they are equal it passes the cascade input through,
//   so a cell working on a more significant nibble overrides whatever the less
//   significant nibbles concluded.
//   iA, iB     4-bit nibbles
//   iCascade   result of the less significant nibbles (one-hot GT/LT/EQ)
//   oResult    combined result (one-hot GT/LT/EQ)
// -----------------------------------------------------------------------------
module DataCompare4
  import serial_compare_seq_pkg::*;
(
  input  logic [3:0] iA,
  input  logic [3:0] iB,
  input  logic [2:0] iCascade,
  output logic [2:0] oResult
);

  always_comb begin
    // NOTE: default assignment first so every path drives oResult and no latch is inferred.
    oResult = iCascade;
    if (iA > iB) begin
      oResult = CMP_GT;
    end else if (iA < iB) begin
      oResult = CMP_LT;
    end
  end

endmodule

// File: rtl/serial_compare_seq.sv
// -----------------------------------------------------------------------------
// serial_compare_seq
//   Multi-cycle unsigned magnitude comparator. Captures two WIDTH-bit operands
//   on an accepted start, then walks them one nibble per clock, LSB nibble
//   first, through a single DataCompare4 cell whose result is fed back as the
//   next cascade input. After NIB cycles the cascade holds the full-width
//   compare, which is registered on oData and flagged by a one-cycle oDone.
//   Ports:
//     iClk   clock, all state on rising edge
//     iRst   synchronous reset, active-high
//     bus    serial_compare_seq_if.slave (iStart, iData_a/b, oBusy, oDone, oData)
//   WIDTH must be a multiple of 4 and at least 4; the bus interface must be
//   instantiated with the same WIDTH.
//   Timing: start accepted at edge T -> oDone high in the cycle after edge
//   T+NIB; a new start can be accepted every NIB+2 cycles.
// -----------------------------------------------------------------------------
module serial_compare_seq
  import serial_compare_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  serial_compare_seq_if.slave bus
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = idxWidth(NIB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  seqStateT         state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [IDXW-1:0]  idx;
  logic [2:0]       cascade;
  logic [2:0]       cellOut;
  logic [3:0]       nibA;
  logic [3:0]       nibB;
  logic             busyQ;
  logic             doneQ;
  logic [2:0]       dataQ;

  // Current nibble pair; idx never exceeds NIB-1 while the cell output is used.
  always_comb begin
    nibA = opA[4*idx +: 4];
    nibB = opB[4*idx +: 4];
  end

  DataCompare4 uCell (
    .iA       (nibA),
    .iB       (nibB),
    .iCascade (cascade),
    .oResult  (cellOut)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iClk) begin
    // NOTE: reset is synchronous, so it is only a priority branch inside the
    // clocked block; opA/opB are pure datapath and are reloaded on every
    // accepted start, so they are deliberately left out of reset.
    if (iRst) begin
      state   <= IDLE;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      dataQ   <= CMP_NONE;
      idx     <= '0;
      cascade <= CMP_EQ;
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.iStart) begin
            opA     <= bus.iData_a;
            opB     <= bus.iData_b;
            idx     <= '0;
            cascade <= CMP_EQ;   // empty prefix compares equal
            dataQ   <= CMP_NONE;
            busyQ   <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          cascade <= cellOut;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            dataQ <= cellOut;
            doneQ <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Starts seen in RUN/DONE are dropped; nothing is queued.
          busyQ <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busyQ <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oBusy = busyQ;
  assign bus.oDone = doneQ;
  assign bus.oData = dataQ;

endmodule

// File: tb/tb_serial_compare_seq.sv
// -----------------------------------------------------------------------------
// tb_serial_compare_seq
//   Three comparators (WIDTH = 4, 16, 32) share clock and reset. Directed cases
//   run on the 16-bit instance; then all three receive randomized operands with
//   iStart held high. Each accepted start pushes the expected result and the
//   cycle its oDone must appear in into a per-instance queue; a negedge monitor
//   pops and compares on every oDone and checks the one-hot invariant.
// -----------------------------------------------------------------------------
module tb_serial_compare_seq;

  localparam int NRAND = 2000;

  typedef struct {
    logic [2:0] data;
    int         cyc;
  } expT;

  expT  expQ[3][$];
  logic iClk = 1'b0;
  logic iRst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   monOn = 1'b0;

  logic [31:0] a4, b4, a16, b16, a32, b32;

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  serial_compare_seq_if #(.WIDTH(4))  if4  ();
  serial_compare_seq_if #(.WIDTH(16)) if16 ();
  serial_compare_seq_if #(.WIDTH(32)) if32 ();

  serial_compare_seq #(.WIDTH(4))  u4  (.iClk(iClk), .iRst(iRst), .bus(if4));
  serial_compare_seq #(.WIDTH(16)) u16 (.iClk(iClk), .iRst(iRst), .bus(if16));
  serial_compare_seq #(.WIDTH(32)) u32 (.iClk(iClk), .iRst(iRst), .bus(if32));

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain full-width unsigned comparison.
  function automatic logic [2:0] refCmp(input logic [31:0] a, input logic [31:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int nibOf(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // Called #1 after the accept edge: oDone is due NIB edges later.
  task automatic pushExp(input int k, input logic [2:0] d);
    expT e;
    e.data = d;
    e.cyc  = cyc + nibOf(k);
    expQ[k].push_back(e);
  endtask

  task automatic genPair(input int w, output logic [31:0] a, output logic [31:0] b);
    logic [31:0] mask;
    int          mode;
    int          n;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    mode = int'($urandom_range(0, 3));
    a    = $urandom & mask;
    case (mode)
      0: b = a;
      1: begin
        n = int'($urandom_range(0, w / 4 - 1));
        b = a ^ (32'($urandom_range(1, 15)) << (4 * n));
      end
      default: b = $urandom & mask;
    endcase
  endtask

  task automatic drain(input int k, input int maxCyc);
    int n = 0;
    while (expQ[k].size() != 0 && n < maxCyc) begin
      @(posedge iClk);
      n++;
    end
    #1;
    check($sformatf("inst%0d pending compares at timeout", k), 32'(expQ[k].size()), 0);
  endtask

  task automatic monStep(input int k, input logic done, input logic busy, input logic [2:0] data);
    expT e;
    check($sformatf("inst%0d oData one-hot or zero", k),
          32'(data inside {3'b000, 3'b001, 3'b010, 3'b100}), 1);
    if (done) begin
      if (expQ[k].size() == 0) begin
        check($sformatf("inst%0d oDone without pending compare", k), 32'(done), 0);
      end else begin
        e = expQ[k].pop_front();
        check($sformatf("inst%0d oData result", k), 32'(data), 32'(e.data));
        check($sformatf("inst%0d oDone cycle", k), 32'(cyc), 32'(e.cyc));
        check($sformatf("inst%0d oBusy during oDone", k), 32'(busy), 1);
      end
    end
  endtask

  always @(negedge iClk) begin
    if (monOn) begin
      monStep(0, if4.oDone,  if4.oBusy,  if4.oData);
      monStep(1, if16.oDone, if16.oBusy, if16.oData);
      monStep(2, if32.oDone, if32.oBusy, if32.oData);
    end
  end

  // Directed start on the 16-bit instance; operands are inverted right after
  // acceptance to prove they were latched.
  task automatic start16(input logic [15:0] a, input logic [15:0] b);
    if16.iData_a = a;
    if16.iData_b = b;
    if16.iStart  = 1'b1;
    @(posedge iClk);
    #1;
    if16.iStart = 1'b0;
    pushExp(1, refCmp(32'(a), 32'(b)));
    if16.iData_a = ~a;
    if16.iData_b = ~b;
    check("w16 oBusy after accept", 32'(if16.oBusy), 1);
    check("w16 oData cleared on accept", 32'(if16.oData), 0);
  endtask

  task automatic finish16(input logic [2:0] exp);
    drain(1, 20);
    repeat (6) @(posedge iClk);
    #1;
    check("w16 oBusy back in idle", 32'(if16.oBusy), 0);
    check("w16 oData held", 32'(if16.oData), 32'(exp));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    iRst = 1'b1;
    if4.iStart  = 1'b1; if4.iData_a  = 4'h9;      if4.iData_b  = 4'h3;
    if16.iStart = 1'b1; if16.iData_a = 16'hBEEF;  if16.iData_b = 16'h1;
    if32.iStart = 1'b1; if32.iData_a = 32'h1;     if32.iData_b = 32'h2;

    // Reset held two cycles with start asserted: nothing may be accepted.
    repeat (2) @(posedge iClk);
    #1;
    monOn = 1'b1;
    check("w4 reset oBusy",  32'(if4.oBusy), 0);
    check("w4 reset oData",  32'(if4.oData), 0);
    check("w16 reset oBusy", 32'(if16.oBusy), 0);
    check("w16 reset oDone", 32'(if16.oDone), 0);
    check("w16 reset oData", 32'(if16.oData), 0);
    check("w32 reset oBusy", 32'(if32.oBusy), 0);
    check("w32 reset oData", 32'(if32.oData), 0);
    if4.iStart  = 1'b0;
    if16.iStart = 1'b0;
    if32.iStart = 1'b0;
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    check("w16 idle after reset release", 32'(if16.oBusy), 0);

    // Equal operands, then MSB-nibble override, then plain less-than.
    start16(16'h1234, 16'h1234);
    finish16(3'b001);
    start16(16'h8000, 16'h7FFF);
    finish16(3'b100);
    start16(16'h0001, 16'h0002);
    finish16(3'b010);

    // Second start pulsed mid-RUN must be ignored.
    start16(16'hFFFF, 16'h0000);
    @(posedge iClk);
    #1;
    if16.iData_a = 16'h0000;
    if16.iData_b = 16'h0001;
    if16.iStart  = 1'b1;
    @(posedge iClk);
    #1;
    if16.iStart = 1'b0;
    check("w16 busy while restart ignored", 32'(if16.oBusy), 1);
    finish16(3'b100);

    // Reset in the second RUN cycle abandons the compare.
    if16.iData_a = 16'h0005;
    if16.iData_b = 16'h0003;
    if16.iStart  = 1'b1;
    @(posedge iClk);
    #1;
    if16.iStart = 1'b0;
    @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    check("w16 oBusy after mid-run reset", 32'(if16.oBusy), 0);
    check("w16 oDone after mid-run reset", 32'(if16.oDone), 0);
    check("w16 oData after mid-run reset", 32'(if16.oData), 0);
    repeat (8) @(posedge iClk);
    #1;
    check("w16 oData stays clear after abandon", 32'(if16.oData), 0);
    start16(16'hABCD, 16'hABCE);
    finish16(3'b010);

    // Randomized back-to-back compares with iStart held high.
    fork
      begin
        for (int k = 0; k < NRAND; k++) begin
          genPair(4, a4, b4);
          if4.iData_a = a4[3:0];
          if4.iData_b = b4[3:0];
          if4.iStart  = 1'b1;
          @(posedge iClk);
          #1;
          pushExp(0, refCmp(a4, b4));
          if (k == NRAND - 1) if4.iStart = 1'b0;
          if4.iData_a = 4'($urandom);
          if4.iData_b = 4'($urandom);
          repeat (2) @(posedge iClk);
          #1;
        end
      end
      begin
        for (int k = 0; k < NRAND; k++) begin
          genPair(16, a16, b16);
          if16.iData_a = a16[15:0];
          if16.iData_b = b16[15:0];
          if16.iStart  = 1'b1;
          @(posedge iClk);
          #1;
          pushExp(1, refCmp(a16, b16));
          if (k == NRAND - 1) if16.iStart = 1'b0;
          if16.iData_a = 16'($urandom);
          if16.iData_b = 16'($urandom);
          repeat (5) @(posedge iClk);
          #1;
        end
      end
      begin
        for (int k = 0; k < NRAND; k++) begin
          genPair(32, a32, b32);
          if32.iData_a = a32;
          if32.iData_b = b32;
          if32.iStart  = 1'b1;
          @(posedge iClk);
          #1;
          pushExp(2, refCmp(a32, b32));
          if (k == NRAND - 1) if32.iStart = 1'b0;
          if32.iData_a = $urandom;
          if32.iData_b = $urandom;
          repeat (9) @(posedge iClk);
          #1;
        end
      end
    join

    drain(0, 40);
    drain(1, 40);
    drain(2, 40);
    repeat (4) @(posedge iClk);
    #1;
    check("w4 idle at end",  32'(if4.oBusy), 0);
    check("w32 idle at end", 32'(if32.oBusy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
